// File: rtl/opna_pkg.sv
`default_nettype none
// ============================================================================
// Module   : opna_pkg
// Purpose  : Shared types and constants for the OPNA ADPCM-B memory responder
// Revision : 1.0 - initial release
// ============================================================================
package opna_pkg;

  // OPNA ADPCM-B RAM port byte-address width (256 KiB window)
  localparam int ADPCM_AW = 18;

  // Responder FSM states
  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_WR   = 2'd1,
    FSM_RD   = 2'd2
  } fsm_state_e;

  // Plain-vector encodings of the FSM states for the state register
  localparam logic [1:0] c_st_idle = FSM_IDLE;
  localparam logic [1:0] c_st_wr   = FSM_WR;
  localparam logic [1:0] c_st_rd   = FSM_RD;

  // One buffered OPNA write
  typedef struct packed {
    logic [ADPCM_AW-1:0] addr;
    logic [7:0]          data;
  } wr_entry_t;

  localparam int WR_ENTRY_W = $bits(wr_entry_t);

endpackage
`default_nettype wire

// File: rtl/opna_wfifo.sv
`default_nettype none
// ============================================================================
// Module   : opna_wfifo
// Purpose  : Small synchronous FIFO with full/empty flags; a push is accepted
//            while full when a pop happens in the same cycle
// Revision : 1.0 - initial release
// ============================================================================
module opna_wfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_aw:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (c_aw+1)'(DEPTH));
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/opna_adpcm_mem.sv
`default_nettype none
// ============================================================================
// Module   : opna_adpcm_mem
// Purpose  : OPNA ADPCM-B RAM responder; turns level read/write strobes into
//            req/ack transactions on a variable-latency memory backend
// Revision : 1.0 - initial release
// ============================================================================
module opna_adpcm_mem
  import opna_pkg::*;
#(
  parameter int                WFIFO_DEPTH = 4,
  parameter int                MEM_AW      = 25,
  parameter logic [MEM_AW-1:0] MEM_BASE    = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADPCM_AW-1:0] adpcm_addr,
  input  logic                adpcm_roe,
  input  logic                adpcm_wr,
  input  logic [7:0]          adpcm_dout,
  output logic [7:0]          adpcm_din,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic                mem_req,
  output logic                mem_we,
  output logic [7:0]          mem_wdata,
  input  logic [7:0]          mem_rdata,
  input  logic                mem_ack,
  output logic                busy,
  output logic                wr_ovf
);

  // Offset is ORed into the base; the base has its low 18 bits clear
  function automatic logic [MEM_AW-1:0] f_map(input logic [ADPCM_AW-1:0] a);
    return MEM_BASE | MEM_AW'(a);
  endfunction

  logic [ADPCM_AW-1:0] r_addr_q, r_addr_d;
  logic                r_roe_q, r_roe_d;
  logic                r_wr_q, r_wr_d;
  logic [7:0]          r_dout_q;
  logic                w_wr_rise, w_rd_trig;

  logic                r_push;
  wr_entry_t           r_push_entry;
  wr_entry_t           w_head;
  logic                w_fifo_full, w_fifo_empty, w_fifo_pop;
  logic                r_wr_ovf;

  logic                r_rd_pend, r_rd_retrig;
  logic [ADPCM_AW-1:0] r_rd_addr;

  logic [1:0]          r_state;
  logic                w_start_wr, w_start_rd;
  logic                r_mem_req, r_mem_we;
  logic [MEM_AW-1:0]   r_mem_addr;
  logic [7:0]          r_mem_wdata;
  logic [7:0]          r_din;

  // Register the OPNA-side inputs once, then keep a delayed copy for edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_q <= '0;
      r_addr_d <= '0;
      r_roe_q  <= 1'b0;
      r_roe_d  <= 1'b0;
      r_wr_q   <= 1'b0;
      r_wr_d   <= 1'b0;
      r_dout_q <= '0;
    end else begin
      r_addr_q <= adpcm_addr;
      r_addr_d <= r_addr_q;
      r_roe_q  <= adpcm_roe;
      r_roe_d  <= r_roe_q;
      r_wr_q   <= adpcm_wr;
      r_wr_d   <= r_wr_q;
      r_dout_q <= adpcm_dout;
    end
  end

  assign w_wr_rise = r_wr_q & ~r_wr_d;
  assign w_rd_trig = r_roe_q & (~r_roe_d | (r_addr_q != r_addr_d));

  // Stage a detected write for the FIFO one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_push       <= 1'b0;
      r_push_entry <= '0;
    end else begin
      r_push <= w_wr_rise;
      if (w_wr_rise) begin
        r_push_entry.addr <= r_addr_q;
        r_push_entry.data <= r_dout_q;
      end
    end
  end

  assign w_fifo_pop = (r_state == c_st_wr) & mem_ack;

  opna_wfifo #(
    .DEPTH (WFIFO_DEPTH),
    .WIDTH (WR_ENTRY_W)
  ) u_wfifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push),
    .i_wdata (r_push_entry),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Sticky flag for a write that found the FIFO full with no pop to free a slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_wr_ovf <= 1'b0;
    else if (r_push & w_fifo_full & ~w_fifo_pop) r_wr_ovf <= 1'b1;
  end

  // A staged push counts as a pending write so a read never overtakes it
  assign w_start_wr = (r_state == c_st_idle) & ~w_fifo_empty;
  assign w_start_rd = (r_state == c_st_idle) & w_fifo_empty & ~r_push & r_rd_pend;

  // Read-pending bookkeeping: newest trigger address wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pend   <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_retrig <= 1'b0;
    end else begin
      if (w_rd_trig) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= r_addr_q;
      end else if ((r_state == c_st_rd) & mem_ack & ~r_rd_retrig) begin
        r_rd_pend <= 1'b0;
      end
      if (w_start_rd)                           r_rd_retrig <= w_rd_trig;
      else if ((r_state == c_st_rd) & w_rd_trig) r_rd_retrig <= 1'b1;
    end
  end

  // Transaction FSM; request fields are latched at launch and held until ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_st_idle;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= MEM_BASE;
      r_mem_wdata <= '0;
      r_din       <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_start_wr) begin
            r_state     <= c_st_wr;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= f_map(w_head.addr);
            r_mem_wdata <= w_head.data;
          end else if (w_start_rd) begin
            r_state    <= c_st_rd;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= f_map(r_rd_addr);
          end
        end
        c_st_wr: begin
          if (mem_ack) begin
            r_state   <= c_st_idle;
            r_mem_req <= 1'b0;
          end
        end
        c_st_rd: begin
          if (mem_ack) begin
            r_state   <= c_st_idle;
            r_mem_req <= 1'b0;
            r_din     <= mem_rdata;
          end
        end
        default: begin
          r_state   <= c_st_idle;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign adpcm_din = r_din;
  assign mem_addr  = r_mem_addr;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign wr_ovf    = r_wr_ovf;
  assign busy      = (r_state != c_st_idle) | ~w_fifo_empty | r_rd_pend | r_push;

endmodule
`default_nettype wire

// File: tb/tb_opna_adpcm_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_opna_adpcm_mem
// Purpose  : Directed self-checking bench for opna_adpcm_mem with a small
//            latency-programmable backend memory model
// Revision : 1.0 - initial release
// ============================================================================
module tb_opna_adpcm_mem;

  localparam logic [24:0] C_BASE = 25'h1000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] adpcm_addr;
  logic        adpcm_roe, adpcm_wr;
  logic [7:0]  adpcm_dout, adpcm_din;
  logic [24:0] mem_addr;
  logic        mem_req, mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        busy, wr_ovf;

  always #5 clk = ~clk;

  opna_adpcm_mem #(
    .WFIFO_DEPTH (4),
    .MEM_AW      (25),
    .MEM_BASE    (C_BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .adpcm_addr (adpcm_addr),
    .adpcm_roe  (adpcm_roe),
    .adpcm_wr   (adpcm_wr),
    .adpcm_dout (adpcm_dout),
    .adpcm_din  (adpcm_din),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .wr_ovf     (wr_ovf)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Backend model: acts 2 time units after each rising edge
  int          be_lat       = 5;
  bit          be_hold      = 1'b0;
  bit          be_force_ack = 1'b0;
  int          be_cnt       = 0;
  logic [7:0]  bmem [0:1023];
  logic [31:0] log_addr [$];
  logic        log_we   [$];
  logic [7:0]  log_data [$];

  task automatic do_txn();
    log_addr.push_back(32'(mem_addr));
    log_we.push_back(mem_we);
    if (mem_we) begin
      bmem[mem_addr[9:0]] = mem_wdata;
      log_data.push_back(mem_wdata);
    end else begin
      mem_rdata = bmem[mem_addr[9:0]];
      log_data.push_back(mem_rdata);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_data.delete();
  endtask

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 1'b0;
      if (be_force_ack) begin
        be_force_ack = 1'b0;
        mem_ack      = 1'b1;
        be_cnt       = 0;
        if (mem_req) do_txn();
      end else if (rst || !mem_req) begin
        be_cnt = 0;
      end else if (!be_hold) begin
        be_cnt++;
        if (be_cnt >= be_lat) begin
          mem_ack = 1'b1;
          be_cnt  = 0;
          do_txn();
        end
      end
    end
  end

  // Request fields must not move while a request is outstanding
  int          stab_err = 0;
  logic        p_req    = 1'b0;
  logic [24:0] p_addr;
  logic        p_we;
  logic [7:0]  p_wdata;
  always @(negedge clk) begin
    if (mem_req && p_req && (mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wdata))
      stab_err++;
    p_req   = mem_req;
    p_addr  = mem_addr;
    p_we    = mem_we;
    p_wdata = mem_wdata;
  end

  task automatic wait_idle(input string tag);
    int i;
    repeat (4) @(negedge clk);
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && !mem_req) break;
    end
    if (i >= 400) chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_req(input string tag);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    if (i >= 100) chk({tag, "_req_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wr_pulse(input logic [17:0] a, input logic [7:0] d);
    @(negedge clk);
    adpcm_addr = a;
    adpcm_dout = d;
    adpcm_wr   = 1'b1;
    @(negedge clk);
    adpcm_wr   = 1'b0;
  endtask

  function automatic int count_reads();
    int n = 0;
    foreach (log_we[i]) if (!log_we[i]) n++;
    return n;
  endfunction

  initial begin
    adpcm_addr = '0;
    adpcm_roe  = 1'b0;
    adpcm_wr   = 1'b0;
    adpcm_dout = '0;
    for (int i = 0; i < 1024; i++) bmem[i] = 8'h00;
    bmem[10'h123] = 8'hA5;
    bmem[10'h100] = 8'h11;
    bmem[10'h101] = 8'h22;
    bmem[10'h102] = 8'h33;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_din",   32'(adpcm_din), 32'h00);
    chk("rst_req",   32'(mem_req),   32'd0);
    chk("rst_we",    32'(mem_we),    32'd0);
    chk("rst_addr",  32'(mem_addr),  32'(C_BASE));
    chk("rst_wdata", 32'(mem_wdata), 32'h00);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_ovf",   32'(wr_ovf),    32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain read with an empty FIFO, backend latency 5
    clear_log();
    be_lat     = 5;
    adpcm_addr = 18'h00123;
    adpcm_roe  = 1'b1;
    wait_idle("rd1");
    chk("rd1_nreq", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() >= 1) begin
      chk("rd1_addr", log_addr[0], 32'(C_BASE) | 32'h123);
      chk("rd1_we",   32'(log_we[0]), 32'd0);
    end
    chk("rd1_din", 32'(adpcm_din), 32'hA5);
    adpcm_roe = 1'b0;
    repeat (6) @(negedge clk);
    chk("rd1_hold", 32'(adpcm_din), 32'hA5);

    // Write then read of the same address; write must land first
    clear_log();
    wr_pulse(18'h00010, 8'h3C);
    adpcm_roe = 1'b1;
    wait_idle("wr_rd");
    chk("wr_rd_n", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() >= 2) begin
      chk("wr_rd_we0",   32'(log_we[0]),   32'd1);
      chk("wr_rd_addr0", log_addr[0],      32'(C_BASE) | 32'h10);
      chk("wr_rd_data0", 32'(log_data[0]), 32'h3C);
      chk("wr_rd_we1",   32'(log_we[1]),   32'd0);
      chk("wr_rd_addr1", log_addr[1],      32'(C_BASE) | 32'h10);
    end
    chk("wr_rd_din", 32'(adpcm_din), 32'h3C);
    adpcm_roe = 1'b0;
    repeat (3) @(negedge clk);

    // FIFO overflow with the backend stalled
    clear_log();
    be_lat  = 2;
    be_hold = 1'b1;
    for (int i = 0; i < 5; i++) wr_pulse(18'h00200 + 18'(i), 8'h50 + 8'(i));
    repeat (6) @(negedge clk);
    chk("ovf_flag",  32'(wr_ovf), 32'd1);
    chk("ovf_noack", 32'(log_addr.size()), 32'd0);
    be_hold = 1'b0;
    wait_idle("ovf");
    chk("ovf_n", 32'(log_addr.size()), 32'd4);
    if (log_addr.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("ovf_addr%0d", i), log_addr[i], 32'(C_BASE) | (32'h200 + 32'(i)));
        chk($sformatf("ovf_data%0d", i), 32'(log_data[i]), 32'h50 + 32'(i));
      end
    end
    chk("ovf_sticky", 32'(wr_ovf), 32'd1);

    // Latest-wins read while a read is in flight
    clear_log();
    be_lat = 8;
    @(negedge clk);
    adpcm_addr = 18'h00100;
    adpcm_roe  = 1'b1;
    wait_req("lw");
    @(negedge clk);
    adpcm_addr = 18'h00101;
    repeat (2) @(negedge clk);
    adpcm_addr = 18'h00102;
    wait_idle("lw");
    chk("lw_nreads", 32'(count_reads()), 32'd2);
    if (log_addr.size() >= 2) begin
      chk("lw_addr0", log_addr[0], 32'(C_BASE) | 32'h100);
      chk("lw_addr1", log_addr[1], 32'(C_BASE) | 32'h102);
    end
    chk("lw_din", 32'(adpcm_din), 32'h33);
    adpcm_roe = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a read; stray ack afterwards
    be_lat = 20;
    @(negedge clk);
    adpcm_addr = 18'h00050;
    adpcm_roe  = 1'b1;
    wait_req("mr");
    repeat (2) @(negedge clk);
    rst       = 1'b1;
    adpcm_roe = 1'b0;
    #1;
    chk("mr_req_async", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    @(negedge clk);
    be_force_ack = 1'b1;
    repeat (4) @(negedge clk);
    chk("mr_req",  32'(mem_req),         32'd0);
    chk("mr_din",  32'(adpcm_din),       32'h00);
    chk("mr_busy", 32'(busy),            32'd0);
    chk("mr_ovf",  32'(wr_ovf),          32'd0);
    chk("mr_nlog", 32'(log_addr.size()), 32'd0);

    // Push and pop in the same cycle with the FIFO full
    clear_log();
    be_lat  = 3;
    be_hold = 1'b1;
    for (int i = 0; i < 4; i++) wr_pulse(18'h00300 + 18'(i), 8'h60 + 8'(i));
    repeat (4) @(negedge clk);
    chk("pp_cnt_pre", 32'(dut.u_wfifo.r_count), 32'd4);
    adpcm_addr = 18'h00304;
    adpcm_dout = 8'h64;
    adpcm_wr   = 1'b1;
    @(negedge clk);
    adpcm_wr     = 1'b0;
    be_force_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("pp_cnt_post", 32'(dut.u_wfifo.r_count), 32'd4);
    chk("pp_ovf",      32'(wr_ovf),              32'd0);
    be_hold = 1'b0;
    wait_idle("pp");
    chk("pp_n", 32'(log_addr.size()), 32'd5);
    if (log_addr.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("pp_addr%0d", i), log_addr[i], 32'(C_BASE) | (32'h300 + 32'(i)));
        chk($sformatf("pp_data%0d", i), 32'(log_data[i]), 32'h60 + 32'(i));
      end
    end
    chk("pp_ovf_end", 32'(wr_ovf), 32'd0);

    chk("req_stable", 32'(stab_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/opna_adpcm_mem.md
Name: opna_adpcm_mem

Overview:
- Memory responder on the far side of the OPNA ADPCM-B RAM port.
- Accepts the OPNA's level-style read/write strobes and converts them into single-request/ack transactions on a variable-latency backend (SDRAM/BRAM arbiter port).
- Buffers writes in a small FIFO and holds the last read byte stable on adpcm_din.
- Sits between the OPNA wrapper and the system memory arbiter, with the 256 KiB ADPCM region mapped at MEM_BASE.

Parameters:
- WFIFO_DEPTH, 4, write FIFO entries; power of 2, minimum 2.
- MEM_AW, 25, backend byte-address width.
- MEM_BASE, 25'h0, backend byte address of ADPCM offset 0; low 18 bits are zero.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- adpcm_addr  in  18  OPNA ADPCM byte address
- adpcm_roe  in  1  OPNA read enable, level
- adpcm_wr  in  1  OPNA write strobe, level
- adpcm_dout  in  8  OPNA write data
- adpcm_din  out  8  read data to OPNA
- mem_addr  out  MEM_AW  backend address
- mem_req  out  1  backend request, held until ack
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_wdata  out  8  backend write data
- mem_rdata  in  8  backend read data; valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- busy  out  1  transaction in flight, FIFO non-empty, or read pending
- wr_ovf  out  1  sticky write-overflow flag

Behaviour:
- Reset: adpcm_din=0, mem_req=0, mem_we=0, mem_addr=MEM_BASE, mem_wdata=0, busy=0, wr_ovf=0. FIFO is emptied, read-pending flag is cleared, FSM goes to IDLE.
- Reset mid-transaction: the outstanding request is abandoned. A stray mem_ack arriving in IDLE is ignored.
- Input sampling:
  - adpcm_addr, adpcm_roe, adpcm_wr and adpcm_dout are registered once.
  - Edges are detected on the registered copies.
- Write capture:
  - A rising edge of adpcm_wr pushes {addr, dout} into the FIFO in the cycle after detection.
  - If the FIFO is full, the write is dropped and wr_ovf is set. wr_ovf clears only on rst.
- Read trigger:
  - Fires on a rising edge of adpcm_roe, or on a change of registered adpcm_addr while adpcm_roe=1.
  - A trigger sets rd_pend and latches rd_addr.
  - A trigger while rd_pend is already set overwrites rd_addr (latest wins).
- FSM states: IDLE, WR, RD.
  - IDLE: if the FIFO is non-empty, go to WR. Writes take priority, so reads never pass earlier writes. Otherwise, if rd_pend, go to RD.
  - WR: mem_req=1, mem_we=1, mem_addr=MEM_BASE|head.addr, mem_wdata=head.data. On mem_ack, pop the FIFO and return to IDLE.
  - RD: mem_req=1, mem_we=0, mem_addr=MEM_BASE|rd_addr. On mem_ack, adpcm_din<=mem_rdata, return to IDLE, and clear rd_pend unless a new trigger arrived during RD; in that case rd_pend stays set and the read is reissued.
- mem_req deasserts in the cycle after mem_ack. There is at least one idle cycle between transactions.
- Request signals (mem_addr, mem_we, mem_wdata) are stable while mem_req=1.
- Simultaneous write edge and read trigger: both are captured, and the write is performed first.
- Simultaneous FIFO push and pop on mem_ack: FIFO occupancy is unchanged and no overflow is flagged.
- Address arithmetic: 18-bit offset OR MEM_BASE with no carry. A wrap at 0x3FFFF is the OPNA's responsibility.
- Latency: adpcm_roe edge to adpcm_din update is 3 + backend cycles with an empty FIFO.
- adpcm_din holds its value between reads.

Decomposition:
- Shared package opna_pkg:
  - ADPCM_AW=18.
  - FSM state enum.
  - write-entry struct {addr[17:0], data[7:0]}.
- One sub-module, opna_wfifo: synchronous FIFO with full/empty flags and push/pop in the same cycle. Reused for any other OPNA-side buffering.

Test Plan:
- Read, empty FIFO, backend ack at fixed 5 cycles: roe rises with addr=0x00123, backend returns 0xA5 → one read request with mem_addr=MEM_BASE|0x00123 and mem_we=0; adpcm_din=0xA5 after ack and held after roe falls.
- Write then read same address: wr pulse addr=0x00010 data=0x3C, roe rises 1 cycle later at 0x00010 → write transaction precedes read; backend model returns 0x3C; adpcm_din=0x3C.
- FIFO overflow: backend ack stalled, 5 wr pulses with WFIFO_DEPTH=4 → 4 writes issued in order after release, 5th dropped, wr_ovf=1 and stays 1.
- Latest-wins read: addr steps 0x100→0x101→0x102 during one in-flight read (ack after 8 cycles) → at most 2 read requests; final adpcm_din equals the data at 0x102.
- Reset mid-RD: assert rst with mem_req=1, ack arrives 2 cycles after rst release → mem_req=0 immediately; stray ack ignored; adpcm_din=0; busy=0.
- Push/pop same cycle: FIFO at 4 entries, ack pops while a new wr edge pushes → no overflow, count stays 4, all data written in order.
